// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding, datapath width and flag-vector layout.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int ALU_WIDTH = 32;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_O = 0;

  // Packs the individual flags into the 4-bit vector used downstream.
  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic o);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_O] = o;
    return f;
  endfunction

endpackage

// File: rtl/serial_sub_32b_if.sv
// Operand/result bus of the bit-serial subtractor.
// Both halves are valid/ready: a beat transfers on a rising edge where valid and ready are both 1;
// the producer holds its payload while valid=1 and ready=0, and ready may depend on state only.
interface serial_sub_32b_if #(
  parameter int WIDTH = 32
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] d;
  logic             c_out;
  logic             sig_N;
  logic             sig_Z;
  logic             sig_C;
  logic             sig_O;

  modport master (
    output start_valid, a, b, c_in, res_ready,
    input  start_ready, res_valid, d, c_out, sig_N, sig_Z, sig_C, sig_O
  );

  modport slave (
    input  start_valid, a, b, c_in, res_ready,
    output start_ready, res_valid, d, c_out, sig_N, sig_Z, sig_C, sig_O
  );
endinterface

// File: rtl/serial_sub_cell.sv
// Single-bit full adder used by the serial datapath.
module serial_sub_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

// File: rtl/serial_sub_32b.sv
// Bit-serial subtractor: D = A + ~B + c_in, one bit per clock LSB first, with N/Z/C/O flags.
module serial_sub_32b
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_sub_32b_if.slave bus,
  output state_e          o_dbg_state
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             r_zacc;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_d;
  logic             r_c_out;
  logic             r_n;
  logic             r_z;
  logic             r_o;

  logic             w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  serial_sub_cell u_cell (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  assign w_res_next = {w_sum, r_res[WIDTH-1:1]};
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_zacc  <= 1'b0;
      r_cnt   <= '0;
      r_d     <= '0;
      r_c_out <= 1'b0;
      r_n     <= 1'b0;
      r_z     <= 1'b0;
      r_o     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start_valid) begin
            r_a     <= bus.a;
            r_b     <= ~bus.b;
            r_carry <= bus.c_in;
            r_cnt   <= '0;
            r_zacc  <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_cout;
          r_res   <= w_res_next;
          r_zacc  <= r_zacc | w_sum;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            // On the MSB edge r_carry is still the carry into the MSB.
            r_d     <= w_res_next;
            r_c_out <= w_cout;
            r_n     <= w_sum;
            r_z     <= ~(r_zacc | w_sum);
            r_o     <= r_carry ^ w_cout;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.start_ready = (r_state == IDLE);
  assign bus.res_valid   = (r_state == DONE);
  assign bus.d           = r_d;
  assign bus.c_out       = r_c_out;
  assign bus.sig_C       = r_c_out;
  assign bus.sig_N       = r_n;
  assign bus.sig_Z       = r_z;
  assign bus.sig_O       = r_o;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_serial_sub_32b.sv
// Self-checking bench for serial_sub_32b: table vectors, random ops, backpressure and mid-run reset.
module tb_serial_sub_32b;
  import alu_pkg::*;

  localparam int W  = ALU_WIDTH;
  localparam int EW = W + 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic [W-1:0] d;
    logic         n;
    logic         z;
    logic         c;
    logic         o;
  } vec_t;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  state_e dbg_state;

  serial_sub_32b_if #(.WIDTH(W)) bus ();

  serial_sub_32b #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain wide addition, flags from their arithmetic definitions.
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
    return {s[W-1:0], pack_flags(s[W-1], s[W-1:0] == '0, s[W],
                                 (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]))};
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic [EW-1:0] exp);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!bus.start_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("start_ready_before_send", bus.start_ready, 1);
    bus.a           = a;
    bus.b           = b;
    bus.c_in        = cin;
    bus.start_valid = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    bus.a           = $urandom;
    bus.b           = $urandom;
    bus.c_in        = 1'($urandom_range(0, 1));
  endtask

  // Called right after the accept edge; counts edges until res_valid.
  task automatic collect();
    int            cyc;
    logic [EW-1:0] e;
    cyc = 0;
    while (!bus.res_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("latency", cyc, W);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: result with empty expected queue");
    end else begin
      e = exp_q.pop_front();
      check("d", bus.d, e[EW-1:4]);
      check("flags_NZCO", pack_flags(bus.sig_N, bus.sig_Z, bus.sig_C, bus.sig_O), e[3:0]);
      check("c_out", bus.c_out, e[FLAG_C]);
    end
  endtask

  task automatic ack();
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check("res_valid_after_ack", bus.res_valid, 0);
    check("start_ready_after_ack", bus.start_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_d"}, bus.d, 0);
    check({tag, "_flags"}, pack_flags(bus.sig_N, bus.sig_Z, bus.sig_C, bus.sig_O), 0);
    check({tag, "_c_out"}, bus.c_out, 0);
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_start_ready"}, bus.start_ready, 1);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  initial begin
    vec_t         vt[8];
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    int           stale;

    bus.start_valid = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.c_in        = 1'b0;
    bus.res_ready   = 1'b0;

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    vt[0] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[1] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[2] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[3] = '{32'h0000_0007, 32'h0000_0007, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[7] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 8; i++) begin
      send(vt[i].a, vt[i].b, vt[i].c_in,
           {vt[i].d, pack_flags(vt[i].n, vt[i].z, vt[i].c, vt[i].o)});
      collect();
      ack();
    end

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i == 0) ? ra : $urandom;
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rc, model(ra, rb, rc));
      collect();
      ack();
    end

    // Backpressure: result must hold while new operands are offered and refused.
    send(32'd5, 32'd3, 1'b1, {32'h0000_0002, pack_flags(1'b0, 1'b0, 1'b1, 1'b0)});
    collect();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.start_valid = 1'b1;
      bus.a           = $urandom;
      bus.b           = $urandom;
      bus.c_in        = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("bp_res_valid", bus.res_valid, 1);
      check("bp_start_ready", bus.start_ready, 0);
      check("bp_d", bus.d, 32'h0000_0002);
      check("bp_flags", pack_flags(bus.sig_N, bus.sig_Z, bus.sig_C, bus.sig_O), 4'b0010);
    end
    @(negedge clk);
    bus.start_valid = 1'b0;
    ack();
    check("bp_state_idle", dbg_state, IDLE);

    send(32'h8000_0000, 32'h0000_0001, 1'b1, model(32'h8000_0000, 32'h0000_0001, 1'b1));
    collect();
    ack();

    // Abandon an operation after 10 bits; outputs must clear without waiting for a clock.
    send(32'hDEAD_BEEF, 32'h0000_0001, 1'b1, model(32'hDEAD_BEEF, 32'h0000_0001, 1'b1));
    repeat (10) @(posedge clk);
    #2;
    check("pre_reset_state", dbg_state, RUN);
    check("pre_reset_d_held", bus.d, 32'h7FFF_FFFF);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_run_reset");
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.res_valid) stale++;
    end
    check("no_stale_result", stale, 0);

    send(32'h1234_5678, 32'h0234_5678, 1'b1,
         {32'h1000_0000, pack_flags(1'b0, 1'b0, 1'b1, 1'b0)});
    collect();
    ack();

    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_sub_32b.md
Name: serial_sub_32b

Overview:
- Bit-serial subtractor: computes D = A - B as A + ~B + c_in, one bit per clock, LSB first.
- Produces the same N/Z/C/O flag set as the parallel adder datapath, for cross-checking and for area-constrained compare paths.
- Operands arrive on a valid/ready start interface; results leave on a valid/ready result interface.
- Sits beside the 32-bit adder in the ALU area as its small, multi-cycle subtract/compare counterpart.

Parameters:
- WIDTH, 32: operand and result width in bits; must be at least 2.
- CNT_W, $clog2(WIDTH)+1: bit-counter width; derived, do not override.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_valid  input  1  operands a, b, c_in are valid.
- start_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- c_in  input  1  carry-in: 1 = no borrow-in, 0 = borrow-in of 1.
- res_valid  output  1  d and flags are valid.
- res_ready  input  1  consumer takes the result.
- d  output  WIDTH  difference, A + ~B + c_in, mod 2^WIDTH.
- c_out  output  1  carry out of the MSB.
- sig_N  output  1  d[WIDTH-1].
- sig_Z  output  1  d == 0.
- sig_C  output  1  equals c_out; 1 means no borrow.
- sig_O  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.

Behaviour:
- Reset (asynchronous, while rst_n = 0):
  - state = IDLE.
  - d, c_out and all sig_* = 0.
  - res_valid = 0.
  - Internal shift registers, carry and counter = 0.
- start_ready is combinational: 1 exactly when state = IDLE, including during reset.
- res_valid is 1 exactly when state = DONE.
- IDLE:
  - On start_valid & start_ready, capture a into the A shift register, ~b into the B shift register, c_in into the carry register.
  - Clear the counter and the zero accumulator, then go to RUN.
  - Otherwise stay in IDLE.
- RUN, one bit per edge:
  - sum = A[0] ^ B[0] ^ carry; carry_next = majority(A[0], B[0], carry).
  - sum shifts into the result shift register from the MSB side; A and B shift right.
  - Zero accumulator ORs in sum.
  - On the edge processing bit WIDTH-1, the current carry (before update) is saved as carry into the MSB.
  - After WIDTH edges (counter reaches WIDTH-1 and processes that bit), go to DONE.
- Transition into DONE loads the output registers:
  - d = result, c_out = sig_C = final carry.
  - sig_N = result MSB, sig_Z = ~accumulator.
  - sig_O = carry into the MSB ^ final carry.
- Latency: with acceptance on edge E0, res_valid rises after edge E_WIDTH, i.e. 32 cycles for the default width.
- DONE:
  - Outputs held stable while res_ready = 0, for any number of cycles.
  - On res_ready = 1, go to IDLE on the next edge.
  - d and flags keep their values in IDLE until the next transition into DONE; they are meaningful only when res_valid = 1.
- start_valid is ignored outside IDLE. A new operand set is accepted no earlier than the cycle after the result handshake, so there is no back-to-back overlap.
- Operand inputs are sampled only on the acceptance edge; later changes have no effect.
- Reset mid-RUN or mid-DONE: the operation is abandoned, all outputs go to their reset values immediately, and no stale result is presented afterwards.
- Flag identities the verifier checks on every result:
  - sig_C = c_out.
  - sig_Z = (d == 0).
  - sig_N = d[WIDTH-1].
  - sig_O = (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]).

Decomposition:
- Shared package alu_pkg:
  - state enum {IDLE, RUN, DONE}.
  - ALU_WIDTH = 32.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_O=0, for packing into a 4-bit flag vector downstream.
- One sub-module, serial_sub_cell: a combinational single-bit full adder (a, b, cin -> sum, cout), instantiated once in the RUN datapath.

Test Plan:
- 5 - 3, c_in=1: d=0x00000002, N0 Z0 C1 O0; res_valid exactly 32 cycles after the accept edge. Same operands with c_in=0: d=0x00000001.
- 0 - 1, c_in=1: d=0xFFFFFFFF, N1 Z0 C0 O0. Then 7 - 7: d=0, N0 Z1 C1 O0.
- Overflow:
  - 0x80000000 - 0x00000001: d=0x7FFFFFFF, N0 C1 O1.
  - 0x7FFFFFFF - 0xFFFFFFFF: d=0x80000000, N1 C0 O1.
- Backpressure: hold res_ready=0 for 10 cycles in DONE, pulsing start_valid with new operands. Outputs stay stable, start_ready=0, the new operands are not accepted; after res_ready=1 the block returns to IDLE and the next op is correct.
- Reset mid-RUN: drop rst_n after 10 bits processed. All outputs go to 0 asynchronously and start_ready=1. The next op, 0x12345678 - 0x02345678, gives 0x10000000 with N0 Z0 C1 O0.
